// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline flow controller
package pipe_pkg;

  // Program counter width used across the fetch path
  localparam int PC_W = 16;

  // Instruction encoding loaded into a squashed pipeline register
  localparam logic [PC_W-1:0] NOP_INSTR = 16'h0000;

  // Saturation ceiling for the statistics and run-length counters
  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  // Controller state, encoded as seen on the state output
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Per-cycle pipeline register controls
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  // Control pattern while the controller is held in reset
  localparam ctrl_t CTRL_RESET    = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
  // Control pattern for a redirect or a squash cycle
  localparam ctrl_t CTRL_SQUASH   = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};
  // Control pattern for a hazard hold
  localparam ctrl_t CTRL_HOLD     = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
  // Control pattern for normal sequential fetch
  localparam ctrl_t CTRL_ADVANCE  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit saturating counter with synchronous clear
module sat_counter16
  import pipe_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [15:0] count
);

  // Clear wins over enable; the count sticks at the ceiling instead of wrapping
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= 16'h0000;
    end else if (enable && (count != SAT_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// rtl/pipe_flow_ctrl.sv - PC owner and IF/ID, ID/EX stall/flush controller
module pipe_flow_ctrl
  import pipe_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          FLUSH_DEPTH = 2,
  parameter int          MAX_STALL   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        mispredict,
  input  logic [15:0] branch_target,
  output logic [15:0] pc,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  state,
  output logic        stall_timeout,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  // Squash counter value loaded on a redirect; depth 1 means no FLUSH cycles
  localparam logic [2:0]  FLUSH_LOAD  = 3'(FLUSH_DEPTH - 1);
  // Run-length value during the stall cycle that trips the watchdog
  localparam logic [15:0] STALL_LIMIT = 16'(MAX_STALL - 1);

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      flush_q;
  logic [2:0]      flush_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            timeout_q;
  logic [15:0]     run_len;
  ctrl_t           ctrl;

  // Qualified events: redirect beats stall, and stalls are ignored while squashing
  logic redirect;
  logic stall_act;

  assign redirect  = !reset && mispredict;
  assign stall_act = !reset && !mispredict && stall_req && (state_q != ST_FLUSH);

  // State register: squash countdown lives alongside the FSM state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      flush_q <= 3'd0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic: redirect from any state, otherwise stall/run or count down the squash
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    if (mispredict) begin
      if (FLUSH_LOAD == 3'd0) begin
        state_d = ST_RUN;
        flush_d = 3'd0;
      end else begin
        state_d = ST_FLUSH;
        flush_d = FLUSH_LOAD;
      end
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          state_d = stall_req ? ST_STALL : ST_RUN;
        end
        ST_FLUSH: begin
          if (flush_q <= 3'd1) begin
            state_d = ST_RUN;
            flush_d = 3'd0;
          end else begin
            flush_d = flush_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          flush_d = 3'd0;
        end
      endcase
    end
  end

  // Output logic: same-cycle response to hazard and redirect inputs
  always_comb begin
    ctrl = CTRL_ADVANCE;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (mispredict) begin
      ctrl = CTRL_SQUASH;
    end else begin
      case (state_q)
        ST_FLUSH: ctrl = CTRL_SQUASH;
        default:  ctrl = stall_req ? CTRL_HOLD : CTRL_ADVANCE;
      endcase
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;

  // Next fetch address: branch target on redirect, else sequential with 16-bit wrap
  always_comb begin
    pc_d = pc_q;
    if (mispredict) begin
      pc_d = branch_target;
    end else if (ctrl.pc_write) begin
      pc_d = pc_q + 16'd1;
    end
  end

  // Program counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Sticky watchdog: set on the stall cycle that completes MAX_STALL in a row
  always_ff @(posedge clock) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (stall_act && (run_len >= STALL_LIMIT)) begin
      timeout_q <= 1'b1;
    end
  end

  sat_counter16 u_stall_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (1'b0),
    .enable (stall_act),
    .count  (stall_count)
  );

  sat_counter16 u_flush_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (1'b0),
    .enable (redirect),
    .count  (flush_count)
  );

  // Run-length restarts on any cycle that is not a qualified stall
  sat_counter16 u_run_len (
    .clock  (clock),
    .reset  (reset),
    .clear  (!stall_act),
    .enable (stall_act),
    .count  (run_len)
  );

  assign pc            = pc_q;
  assign state         = state_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb/tb_pipe_flow_ctrl.sv - directed self-checking bench for pipe_flow_ctrl
module tb_pipe_flow_ctrl;

  logic        clock;
  logic        reset;
  logic        stall_req;
  logic        mispredict;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  state;
  logic        stall_timeout;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  int errors;
  int checks;

  pipe_flow_ctrl #(
    .RESET_PC    (16'h0040),
    .FLUSH_DEPTH (2),
    .MAX_STALL   (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall_req     (stall_req),
    .mispredict    (mispredict),
    .branch_target (branch_target),
    .pc            (pc),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .state         (state),
    .stall_timeout (stall_timeout),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let registered outputs settle before anything is read
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check the four combinational controls as {pc_write, ifid_write, ifid_flush, idex_bubble}
  task automatic chk_ctrl(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_bubble}, {28'd0, exp});
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    stall_req     = 1'b0;
    mispredict    = 1'b0;
    branch_target = 16'h0000;

    // Reset state
    tick();
    chk("rst_pc", pc, 16'h0040);
    chk("rst_state", state, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
    chk("rst_timeout", stall_timeout, 0);
    chk_ctrl("rst_ctrl", 4'b0011);

    // Idle fetch from RESET_PC
    reset = 1'b0;
    chk_ctrl("run_ctrl", 4'b1100);
    chk("idle_pc0", pc, 16'h0040);
    tick();
    chk("idle_pc1", pc, 16'h0041);
    tick();
    chk("idle_pc2", pc, 16'h0042);
    chk("idle_stall_count", stall_count, 0);

    // Redirect and stall in the same cycle: redirect wins
    mispredict    = 1'b1;
    stall_req     = 1'b1;
    branch_target = 16'h000F;
    chk_ctrl("mp_stall_ctrl", 4'b1011);
    tick();
    chk("mp_stall_pc", pc, 16'h000F);
    chk("mp_stall_state", state, 2);
    chk("mp_stall_flush_count", flush_count, 1);
    chk("mp_stall_stall_count", stall_count, 0);

    // Stall during FLUSH is ignored
    mispredict = 1'b0;
    chk_ctrl("flush_ignores_stall", 4'b1011);
    tick();
    chk("flush_done_pc", pc, 16'h0010);
    chk("flush_done_state", state, 0);
    chk("flush_stall_count", stall_count, 0);

    // Four-cycle stall at pc=0x0010
    chk_ctrl("stall_ctrl", 4'b0001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc_hold", pc, 16'h0010);
      chk("stall_state", state, 1);
    end
    chk("stall_count4", stall_count, 4);
    stall_req = 1'b0;
    chk_ctrl("stall_release_ctrl", 4'b1100);
    tick();
    chk("stall_resume_pc", pc, 16'h0011);
    chk("stall_resume_state", state, 0);
    chk("no_timeout_yet", stall_timeout, 0);

    // Redirect to 0x0200 with a two-cycle squash
    mispredict    = 1'b1;
    branch_target = 16'h0200;
    tick();
    mispredict = 1'b0;
    chk("redir_pc", pc, 16'h0200);
    chk("redir_flush_count", flush_count, 2);
    chk_ctrl("redir_squash_ctrl", 4'b1011);
    tick();
    chk("redir_run_pc", pc, 16'h0201);
    chk("redir_run_state", state, 0);
    chk_ctrl("redir_run_ctrl", 4'b1100);

    // Back-to-back redirects: second one restarts the squash
    mispredict    = 1'b1;
    branch_target = 16'h0300;
    tick();
    branch_target = 16'h0400;
    tick();
    chk("restart_pc", pc, 16'h0400);
    chk("restart_state", state, 2);
    chk("restart_flush_count", flush_count, 4);
    mispredict = 1'b0;
    tick();
    chk("restart_run_pc", pc, 16'h0401);
    chk("restart_run_state", state, 0);

    // Watchdog: MAX_STALL=8, hold stall for 10 cycles
    stall_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) chk("wd_before", stall_timeout, 0);
      if (i == 8) chk("wd_set", stall_timeout, 1);
    end
    chk("wd_stall_count", stall_count, 14);
    stall_req = 1'b0;
    tick();
    chk("wd_sticky", stall_timeout, 1);
    chk("wd_resume_pc", pc, 16'h0402);

    // PC wrap at 16'hFFFF
    mispredict    = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    mispredict = 1'b0;
    chk("wrap_pc_fffe", pc, 16'hFFFE);
    tick();
    chk("wrap_pc_ffff", pc, 16'hFFFF);
    tick();
    chk("wrap_pc_0000", pc, 16'h0000);
    chk("wrap_flush_count", flush_count, 5);

    // Reset in the middle of a FLUSH
    mispredict    = 1'b1;
    branch_target = 16'h1234;
    tick();
    chk("pre_reset_state", state, 2);
    mispredict = 1'b0;
    reset      = 1'b1;
    chk_ctrl("mid_reset_ctrl", 4'b0011);
    tick();
    chk("post_reset_pc", pc, 16'h0040);
    chk("post_reset_state", state, 0);
    chk("post_reset_flush_count", flush_count, 0);
    chk("post_reset_stall_count", stall_count, 0);
    chk("post_reset_timeout", stall_timeout, 0);
    reset = 1'b0;
    tick();
    chk("post_reset_run_pc", pc, 16'h0041);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
# pipe_flow_ctrl

Pipeline flow controller that consumes the hazard unit's stall request and branch-misprediction flag and turns them into the PC register and per-stage write/flush/bubble controls. It owns the 16-bit program counter, redirects fetch to the branch target on a misprediction, squashes wrong-path instructions, and keeps stall and flush statistics plus a deadlock watchdog. It sits between the hazard controller and the IF/ID and ID/EX pipeline registers.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- FLUSH_DEPTH, 2, cycles of squash after a redirect (1..7).
- MAX_STALL, 64, consecutive stall cycles before stall_timeout sets (2..65535).

- clock  in  1  system clock, all state on rising edge.
- reset  in  1  reset, synchronous, active-high.
- stall_req  in  1  hazard unit requests hold of PC and IF/ID.
- mispredict  in  1  branch resolved opposite to prediction.
- branch_target  in  16  correct-path PC, valid when mispredict=1.
- pc  out  16  current fetch address, registered.
- pc_write  out  1  PC advances/loads at next edge.
- ifid_write  out  1  IF/ID register captures at next edge.
- ifid_flush  out  1  IF/ID register loads NOP at next edge.
- idex_bubble  out  1  ID/EX register loads NOP (control zeroed) at next edge.
- state  out  2  RUN=0, STALL=1, FLUSH=2.
- stall_timeout  out  1  sticky watchdog flag.
- stall_count  out  16  saturating count of stall cycles.
- flush_count  out  16  saturating count of redirects.

## Operation
- Reset (reset=1 at edge): pc=RESET_PC, state=RUN, flush counter=0, stall run-length=0, stall_count=0, flush_count=0, stall_timeout=0. While reset=1 outputs forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
- Priority per cycle: reset > mispredict > stall_req > normal.
- RUN, no request: pc_write=1, pc<=pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000); ifid_write=1; flush/bubble=0.
- stall_req (no mispredict), in RUN or STALL: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1; state->STALL; stall_count+1 saturating at 16'hFFFF; run-length+1. stall_req low in STALL: RUN behaviour that cycle, state->RUN, run-length cleared.
- Watchdog: when run-length reaches MAX_STALL, stall_timeout<=1; cleared only by reset.
- mispredict, any state: pc<=branch_target, pc_write=1, ifid_write=0, ifid_flush=1, idex_bubble=1; flush_count+1 saturating; state->FLUSH with counter=FLUSH_DEPTH-1 (FLUSH_DEPTH=1 -> state->RUN); run-length cleared; stall_req ignored.
- FLUSH: pc_write=1 (pc<=pc+1), ifid_flush=1, idex_bubble=1, ifid_write=0, stall_req ignored; counter decrements; at counter=1 -> RUN next edge. mispredict in FLUSH restarts redirect (new target, counter reloaded, flush_count+1).
- ifid_write and ifid_flush never both 1.

## Timing
- Control outputs combinational from state and current-cycle inputs (same-cycle stall response); pc, state, counters, flags registered.
- Redirect latency: mispredict in cycle N -> pc=branch_target in cycle N+1; first correct-path instruction enters IF/ID at end of N+1 edge after FLUSH_DEPTH squash cycles complete.
- stall_count/flush_count update at the edge ending the qualifying cycle; visible next cycle.
- stall_timeout rises the cycle after the MAX_STALL-th consecutive stall cycle.
- Reset mid-FLUSH or mid-STALL: aborts immediately, no partial update.

## Structure
- Shared package pipe_pkg: state enum (RUN/STALL/FLUSH), PC width 16, NOP instruction constant 16'h0000.
- One sub-module: sat_counter16 (enable, synchronous clear, saturate at 16'hFFFF), instantiated for stall_count, flush_count, and run-length.

## Test plan
- Reset with RESET_PC=16'h0040, release, 3 idle cycles -> pc 0x0040,0x0041,0x0042; counts 0; pc_write=1.
- stall_req high 4 cycles from pc=0x0010 -> pc holds 0x0010, idex_bubble=1, ifid_write=0, state=STALL, stall_count=4; resumes 0x0011.
- mispredict with branch_target=0x0200 at pc=0x0020, FLUSH_DEPTH=2 -> pc=0x0200 next cycle, ifid_flush=1 for 2 cycles, flush_count=1, RUN on third cycle.
- mispredict and stall_req same cycle, then stall_req during FLUSH -> redirect wins, stall ignored, stall_count unchanged.
- MAX_STALL=8, stall_req held 10 cycles -> stall_timeout=1 after 8th cycle, stays 1 after stall ends until reset.
- pc=0xFFFF free-running -> wraps to 0x0000; reset asserted mid-FLUSH -> pc=RESET_PC, state=RUN next cycle.
